// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, arbiter state encoding and width helpers
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_GAP   = 2'd3
    } arb_state_t;

    // Bits needed to index `value` distinct items; clog2(1) is 0.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting at a pointer
module rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] winner,
    output logic                 found
);

    // Scan from the farthest slot back to the pointer so the slot nearest the
    // pointer is the last assignment and therefore wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                winner = IDX_WIDTH'((int'(ptr) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter with gap and watchdog
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                          clk_sys,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_done,
    output logic                          busy,
    output logic [clog2(NUM_REQ)-1:0]     grant_id,
    output logic                          timeout_err
);

    localparam int IDX_WIDTH = clog2(NUM_REQ);
    localparam int CNT_WIDTH = max2(1, clog2(max2(GAP_CYCLES, TIMEOUT_CYCLES) + 1));

    arb_state_t             state, state_n;
    logic [CNT_WIDTH-1:0]   cnt, cnt_n, cnt_inc;
    logic [IDX_WIDTH-1:0]   ptr, ptr_n;
    logic [IDX_WIDTH-1:0]   win;
    logic                   found;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   tx_valid_n;
    logic [NUM_REQ-1:0]     req_ready_n;
    logic [DATA_WIDTH-1:0]  tx_data_n;
    logic [IDX_WIDTH-1:0]   grant_id_n;
    logic                   timeout_err_n;

    rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .req    (req_valid),
        .ptr    (ptr),
        .winner (win),
        .found  (found)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDX_WIDTH'(i)) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Saturating so a long wait can never wrap and alias a small count.
    assign cnt_inc = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + 1'b1;

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        ptr_n         = ptr;
        tx_valid_n    = 1'b0;
        req_ready_n   = '0;
        tx_data_n     = tx_data;
        grant_id_n    = grant_id;
        timeout_err_n = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (found) begin
                    tx_data_n   = sel_data;
                    req_ready_n = NUM_REQ'(1) << win;
                    tx_valid_n  = 1'b1;
                    grant_id_n  = win;
                    ptr_n       = (win == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    state_n     = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_n = ARB_WAIT;
                cnt_n   = '0;
            end
            ARB_WAIT: begin
                if (tx_done) begin
                    state_n = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
                    cnt_n   = '0;
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES))) begin
                    // Watchdog exit behaves exactly like a late tx_done.
                    timeout_err_n = 1'b1;
                    state_n       = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
                    cnt_n         = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ARB_GAP: begin
                if (cnt_inc == CNT_WIDTH'(GAP_CYCLES)) begin
                    state_n = ARB_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = ARB_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state       <= ARB_IDLE;
            cnt         <= '0;
            ptr         <= '0;
            tx_valid    <= 1'b0;
            req_ready   <= '0;
            tx_data     <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ptr         <= ptr_n;
            tx_valid    <= tx_valid_n;
            req_ready   <= req_ready_n;
            tx_data     <= tx_data_n;
            grant_id    <= grant_id_n;
            timeout_err <= timeout_err_n;
        end
    end

    assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized bench with cycle-level reference model for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int GAP = 5;
    localparam int TO  = 32;

    logic             clk_sys = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             tx_valid;
    logic [DW-1:0]    tx_data;
    logic             tx_done;
    logic             busy;
    logic [1:0]       grant_id;
    logic             timeout_err;

    always #5 clk_sys = ~clk_sys;

    uart_tx_arbiter #(
        .DATA_WIDTH     (DW),
        .NUM_REQ        (NR),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    int n_total = 0;
    int n_pass  = 0;
    int t       = 0;

    // Reference model: the arbiter is free from cycle m_free unless a frame is open.
    bit         m_in_frame = 1'b0;
    int         m_free     = 0;
    int         m_issue    = 0;
    int         m_ptr      = 0;
    int         m_timeouts = 0;
    logic       e_valid, e_busy, e_to;
    logic [3:0] e_ready;
    logic [7:0] e_data = '0;
    logic [1:0] e_gid  = '0;

    logic [NR-1:0] hv;
    logic [7:0]    hd [NR];
    int            pend = -1;
    int            n_to_seen = 0;
    int            glog [$];
    int            dlog [$];
    bit            gap_meas = 1'b0;
    int            gap_done = -1;
    int            gap_next = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, want, t);
    endtask

    task automatic step(input logic r, input logic [NR-1:0] v, input logic [NR*DW-1:0] d,
                        input logic done);
        int w;
        rst       = r;
        req_valid = v;
        req_data  = d;
        tx_done   = done;
        e_valid   = 1'b0;
        e_ready   = '0;
        e_to      = 1'b0;
        if (r) begin
            m_in_frame = 1'b0;
            m_free     = t + 1;
            m_ptr      = 0;
            e_data     = '0;
            e_gid      = '0;
        end else if (!m_in_frame && t >= m_free) begin
            w = -1;
            for (int k = 0; k < NR; k++)
                if (w < 0 && v[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            if (w >= 0) begin
                m_in_frame = 1'b1;
                m_issue    = t + 1;
                m_ptr      = (w + 1) % NR;
                e_valid    = 1'b1;
                e_ready    = 4'(1 << w);
                e_data     = d[w*DW +: DW];
                e_gid      = 2'(w);
            end
        end else if (m_in_frame && t >= m_issue + 1 && done) begin
            m_in_frame = 1'b0;
            m_free     = t + 1 + GAP;
        end else if (m_in_frame && t == m_issue + TO) begin
            m_in_frame = 1'b0;
            m_free     = t + 1 + GAP;
            e_to       = 1'b1;
            m_timeouts++;
        end
        e_busy = m_in_frame || (t + 1 < m_free);

        @(negedge clk_sys);
        t++;
        check("tx_valid",    tx_valid,    e_valid);
        check("req_ready",   req_ready,   e_ready);
        check("busy",        busy,        e_busy);
        check("timeout_err", timeout_err, e_to);
        check("tx_data",     tx_data,     e_data);
        check("grant_id",    grant_id,    e_gid);
        if (tx_valid) begin
            glog.push_back(int'(grant_id));
            dlog.push_back(int'(tx_data));
        end
        if (timeout_err) n_to_seen++;
    endtask

    task automatic do_reset(input int n);
        hv   = '0;
        pend = -1;
        for (int i = 0; i < NR; i++) hd[i] = '0;
        for (int c = 0; c < n; c++) step(1'b1, '0, '0, 1'b0);
        glog.delete();
        dlog.delete();
        n_to_seen  = 0;
        m_timeouts = 0;
    endtask

    task automatic run(input int n, input logic [NR-1:0] mask, input int refill_pct,
                       input bit rand_data, input bit withdraw, input bit mute, input bit spur,
                       input int dmin, input int dmax);
        for (int c = 0; c < n; c++) begin
            logic [NR-1:0]    v;
            logic [NR*DW-1:0] d;
            logic             done;
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) hv[i] = 1'b0;
                else if (withdraw && hv[i] && $urandom_range(0, 39) == 0) hv[i] = 1'b0;
                if (mask[i] && !hv[i] && $urandom_range(1, 100) <= refill_pct) begin
                    hv[i] = 1'b1;
                    hd[i] = rand_data ? 8'($urandom) : 8'(8'h10 + i);
                end
                v[i]            = hv[i];
                d[i*DW +: DW]   = hd[i];
            end
            if (tx_valid && !mute) pend = t + int'($urandom_range(dmin, dmax));
            done = (t == pend) || (spur && $urandom_range(0, 59) == 0);
            if (gap_meas && gap_done < 0 && done) gap_done = t;
            step(1'b0, v, d, done);
            if (gap_meas && gap_done >= 0 && gap_next < 0 && tx_valid) gap_next = t;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_done   = 1'b0;

        // Single request from requester 1.
        do_reset(2);
        hv[1] = 1'b1;
        hd[1] = 8'hA5;
        run(40, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 20);
        check("single_count", glog.size(), 1);
        check("single_gid",  (glog.size() > 0) ? glog[0] : 99, 1);
        check("single_data", (dlog.size() > 0) ? dlog[0] : 999, 32'hA5);

        // Fairness with all four requesters continuously pending.
        do_reset(2);
        run(160, 4'b1111, 100, 1'b0, 1'b0, 1'b0, 1'b0, 20, 20);
        for (int k = 0; k < 5; k++) begin
            check("fair_gid",  (k < glog.size()) ? glog[k] : 99, k % NR);
            check("fair_data", (k < dlog.size()) ? dlog[k] : 999, 32'h10 + (k % NR));
        end

        // Gap spacing between first tx_done and the next start pulse.
        do_reset(2);
        gap_meas = 1'b1;
        gap_done = -1;
        gap_next = -1;
        run(80, 4'b0101, 100, 1'b0, 1'b0, 1'b0, 1'b0, 20, 20);
        gap_meas = 1'b0;
        check("gap_spacing", gap_next - gap_done, GAP + 2);

        // Watchdog: the transmitter never answers.
        do_reset(2);
        run(90, 4'b0011, 100, 1'b0, 1'b0, 1'b1, 1'b0, 20, 20);
        check("wd_pulses", n_to_seen, m_timeouts);
        check("wd_nonzero", n_to_seen > 0, 1);
        check("wd_next_gid", (glog.size() > 1) ? glog[1] : 99, 1);

        // Reset while waiting for tx_done; pointer must restart at 0.
        do_reset(2);
        hv[2] = 1'b1;
        hd[2] = 8'h3C;
        run(10, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 20);
        do_reset(1);
        hv[3] = 1'b1;
        hd[3] = 8'hC3;
        hv[0] = 1'b1;
        hd[0] = 8'h0F;
        run(10, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 20);
        check("rst_first_gid",  (glog.size() > 0) ? glog[0] : 99, 0);
        check("rst_first_data", (dlog.size() > 0) ? dlog[0] : 999, 32'h0F);

        // Random traffic: withdrawals, spurious tx_done, delays around the watchdog limit.
        do_reset(2);
        run(3000, 4'b1111, 30, 1'b1, 1'b1, 1'b0, 1'b1, 1, 40);
        check("rand_timeouts", n_to_seen, m_timeouts);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
